bus_share_arb8: RTL and testbench

Round-robin arbiter and capture stage that shares one 32-bit datapath among eight requesters. It owns the 3-bit select of the downstream 8:1 32-bit select mux and registers the selected word. A configurable hold limit bounds how long one requester may keep the path while others wait. It sits between the requesting units (register file ports, immediate and ALU sources, memory read-back) and the shared result bus of the single-cycle core.

---
 rtl/bus_share_arb8.sv | 120 ++++++++++++
 tb/tb_bus_share_arb8.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_share_arb8.sv
// Round-robin arbiter for eight requesters sharing one 32-bit datapath.
// Drives the downstream 8:1 mux select and registers the selected word.
module bus_share_arb8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [7:0]   req,
  input  logic [255:0] src_data,
  input  logic         stall,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic       cur_req, others, beat;
  logic [2:0] pick_idle, pick_next;

  // First set bit scanning start, start+1, ... (mod 8); descending loop so the
  // lowest offset is written last and wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    cur_req   = req[sel_q];
    others    = |(req & ~(8'b1 << sel_q));
    beat      = (state_q == StGrant) && cur_req && !stall;
    pick_idle = rr_pick(req, ptr_q);
    pick_next = rr_pick(req, sel_q + 3'd1);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    valid_d = beat;
    if (beat) data_d = src_data[{sel_q, 5'd0} +: 32];

    case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (|req) begin
          state_d = StGrant;
          gnt_d   = 8'b1 << pick_idle;
          sel_d   = pick_idle;
          ptr_d   = pick_idle + 3'd1;
          hcnt_d  = '0;
        end
      end
      StGrant: begin
        if ((!cur_req && others) ||
            (beat && hcnt_q == 4'(MAX_HOLD - 1) && others)) begin
          gnt_d  = 8'b1 << pick_next;
          sel_d  = pick_next;
          ptr_d  = pick_next + 3'd1;
          hcnt_d = '0;
        end else if (!cur_req) begin
          state_d = StIdle;
          gnt_d   = '0;
        end else if (beat && hcnt_q != 4'd15) begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      hcnt_q  <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StGrant);

endmodule

// File: tb/tb_bus_share_arb8.sv
// Self-checking bench for bus_share_arb8: directed scenarios plus random
// traffic, all compared against a behavioural round-robin model.
module tb_bus_share_arb8;

  localparam int MaxHold = 4;

  logic         clk = 1'b0;
  logic         nreset;
  logic [7:0]   req;
  logic [255:0] src_data;
  logic         stall;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  bus_share_arb8 #(.MAX_HOLD(MaxHold)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req       (req),
    .src_data  (src_data),
    .stall     (stall),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model: holder index (-1 = nobody), pointer, beat count, last select, capture.
  int          m_cur, m_ptr, m_hcnt, m_sel;
  logic [31:0] m_data;
  logic        m_valid;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [44:0] exp_vec();
    logic [7:0] g;
    g = (m_cur < 0) ? 8'h00 : (8'h01 << m_cur);
    return {g, 3'(m_sel), m_data, m_valid, (m_cur >= 0)};
  endfunction

  function automatic logic [44:0] dut_vec();
    return {gnt, sel, out_data, out_valid, busy};
  endfunction

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic step();
    int  c, w;
    bit  bt, oth;
    if (!nreset) begin
      m_cur = -1; m_ptr = 0; m_hcnt = 0; m_sel = 0; m_data = '0; m_valid = 1'b0;
    end else if (m_cur < 0) begin
      m_valid = 1'b0;
      if (req != 0) begin
        w = pick(req, m_ptr);
        m_cur = w; m_sel = w; m_ptr = (w + 1) % 8; m_hcnt = 0;
      end
    end else begin
      c   = m_cur;
      bt  = req[c] && !stall;
      oth = (req & ~(8'h01 << c)) != 0;
      m_valid = bt;
      if (bt) m_data = src_data[32*c +: 32];
      if ((!req[c] && oth) || (bt && m_hcnt == MaxHold - 1 && oth)) begin
        w = pick(req, (c + 1) % 8);
        m_cur = w; m_sel = w; m_ptr = (w + 1) % 8; m_hcnt = 0;
      end else if (!req[c]) begin
        m_cur = -1;
      end else if (bt) begin
        m_hcnt = (m_hcnt < 15) ? m_hcnt + 1 : 15;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_tagged_src();
    for (int i = 0; i < 8; i++) src_data[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    repeat (2) step();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    req = 8'h08; stall = 1'b0; set_tagged_src();
    do_reset();
    step();
    step();
    nreset = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({gnt, sel, out_data, out_valid, busy} !== 45'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    nreset = 1'b1; req = 8'h01;
    step();
    n_cmp++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_first_grant: got gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_lone_holder();
    do_reset();
    req = 8'h08; stall = 1'b0; set_tagged_src();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (gnt !== 8'h08 || out_valid !== 1'b1 || out_data !== 32'hA5A5_0003) begin
        n_bad++;
        $display("FAIL lone_holder cyc %0d: got gnt=%h v=%b d=%h want gnt=08 v=1 d=a5a50003",
                 i, gnt, out_valid, out_data);
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL lone_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_contention();
    int seq[$];
    int hold[$];
    logic [7:0] prev;
    do_reset();
    req = 8'hFF; stall = 1'b0; set_tagged_src();
    prev = 8'h00;
    for (int i = 0; i < 37; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL contention_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i >= 1) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL contention_valid_gap cyc %0d: got %b want 1", i, out_valid);
        end
      end
      if (gnt != 8'h00) begin
        if (seq.size() == 0 || gnt != prev) begin
          seq.push_back(onehot_idx(gnt));
          hold.push_back(1);
        end else begin
          hold[hold.size()-1]++;
        end
      end
      prev = gnt;
    end
    n_cmp++;
    if (seq.size() < 9) begin
      n_bad++;
      $display("FAIL contention_grant_count: got %0d want >= 9", seq.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_cmp++;
        if (seq[k] != k % 8 || (k < 8 && hold[k] != MaxHold)) begin
          n_bad++;
          $display("FAIL contention_order #%0d: got idx=%0d hold=%0d want idx=%0d hold=%0d",
                   k, seq[k], hold[k], k % 8, MaxHold);
        end
      end
    end
  endtask

  task automatic test_stall();
    int beats;
    logic [7:0] pre;
    do_reset();
    req = 8'h03; stall = 1'b0; set_tagged_src();
    step();
    beats = 0;
    for (int i = 0; i < 2; i++) begin
      pre = gnt; step();
      if (pre == 8'h01 && out_valid) beats++;
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || gnt !== 8'h01) begin
        n_bad++;
        $display("FAIL stall_cycle %0d: got v=%b gnt=%h want v=0 gnt=01", i, out_valid, gnt);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 20 && gnt != 8'h02; i++) begin
      pre = gnt; step();
      if (pre == 8'h01 && out_valid) beats++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL stall_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (beats != MaxHold || gnt !== 8'h02) begin
      n_bad++;
      $display("FAIL stall_beats: got beats=%0d gnt=%h want beats=%0d gnt=02", beats, gnt, MaxHold);
    end
  endtask

  task automatic test_drop_handover();
    do_reset();
    req = 8'h05; stall = 1'b0; set_tagged_src();
    step();
    step();
    req = 8'h04;
    step();
    n_cmp++;
    if (gnt !== 8'h04 || sel !== 3'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_handover: got gnt=%h sel=%0d busy=%b want gnt=04 sel=2 busy=1",
               gnt, sel, busy);
    end
    req = 8'h00;
    step();
    n_cmp++;
    if (gnt !== 8'h00 || sel !== 3'd2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_all: got gnt=%h sel=%0d busy=%b want gnt=00 sel=2 busy=0",
               gnt, sel, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h80; stall = 1'b0; set_tagged_src();
    step();
    req = 8'h00;
    step();
    req = 8'h81;
    step();
    n_cmp++;
    if (gnt !== 8'h01 || sel !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_winner: got gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
    end
    req = 8'h80;
    step();
    n_cmp++;
    if (gnt !== 8'h80 || sel !== 3'd7) begin
      n_bad++;
      $display("FAIL wrap_release: got gnt=%h sel=%0d want gnt=80 sel=7", gnt, sel);
    end
  endtask

  task automatic test_random();
    do_reset();
    req = 8'h00; stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      nreset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 2) == 0)
        req = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      stall = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < 8; w++) src_data[32*w +: 32] = $urandom;
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h want %h (req=%h)", i, dut_vec(), exp_vec(), req);
      end
    end
  endtask

  initial begin
    nreset = 1'b0; req = 8'h00; stall = 1'b0; src_data = '0;
    m_cur = -1; m_ptr = 0; m_hcnt = 0; m_sel = 0; m_data = '0; m_valid = 1'b0;
    test_reset();
    test_lone_holder();
    test_full_contention();
    test_stall();
    test_drop_handover();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
